// File: rtl/rvv_cfg_decoder.sv
// rvv_cfg_decoder: vector front-end that executes vsetvli/vsetivli/vsetvl
// (and optionally vsetsh) locally, owns vtype/vl/vsh, and forwards every
// other vector instruction downstream with a snapshot of that state.
// Optional feature macro: RVV_CFG_VSETSH_EN (enables vsetsh and the vsh register).
// vtype layout: {vill, vma, vta, vsew[1:0], vlmul[2:0]}; zimm[5] (SEW >= 128)
// is always illegal with ELEN <= 64, so it is not stored.
module rvv_cfg_decoder #(
   parameter int unsigned VLEN = 4096,
   parameter int unsigned ELEN = 64,
   parameter int unsigned XLEN = 64
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic                      instr_valid_i,
   output logic                      instr_ready_o,
   input  logic [31:0]               instr_i,
   input  logic [XLEN-1:0]           rs1_i,
   input  logic [XLEN-1:0]           rs2_i,
   output logic                      resp_valid_o,
   output logic [XLEN-1:0]           resp_result_o,
   output logic                      resp_error_o,
   output logic                      ds_valid_o,
   input  logic                      ds_ready_i,
   output logic [31:0]               ds_instr_o,
   output logic [7:0]                ds_vtype_o,
   output logic [$clog2(VLEN):0]     ds_vl_o,
   output logic [7:0]                ds_vsh_o,
   output logic [7:0]                vtype_o,
   output logic [$clog2(VLEN):0]     vl_o,
   output logic [7:0]                vsh_o
);

   localparam int unsigned VLW        = $clog2(VLEN) + 1;
   localparam logic [4:0]  LOG2_VLEN  = 5'($clog2(VLEN));
   localparam logic [4:0]  LOG2_ELEN  = 5'($clog2(ELEN));
   localparam logic [6:0]  OPC_V      = 7'b1010111;
   localparam logic [2:0]  OPCFG      = 3'b111;
   localparam logic [2:0]  LMUL_RSVD  = 3'b100;
   localparam logic [7:0]  VTYPE_VILL = 8'h80;

   typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RESP = 2'd1, ST_ISSUE = 2'd2} state_t;

   // True when the requested vtype cannot be honoured.
   function automatic logic vtype_illegal(input logic [7:0] zimm, input logic rsvd_nz);
      logic [4:0] log2_sew;
      logic [2:0] lmul_neg;
      log2_sew = 5'd3 + {2'b00, zimm[5:3]};
      lmul_neg = 3'd0 - zimm[2:0];
      return rsvd_nz
          | (zimm[2:0] == LMUL_RSVD)
          | (log2_sew > LOG2_ELEN)
          | (zimm[2] & ((log2_sew + {2'b00, lmul_neg}) > LOG2_ELEN));
   endfunction

   state_t           state_q, state_d;
   logic [7:0]       vtype_q, vtype_d;
   logic [VLW-1:0]   vl_q, vl_d;
   logic             resp_valid_q, resp_valid_d;
   logic [XLEN-1:0]  resp_result_q, resp_result_d;
   logic             resp_error_q, resp_error_d;
   logic             ds_valid_q, ds_valid_d;
   logic [31:0]      ds_instr_q, ds_instr_d;
   logic [7:0]       ds_vtype_q, ds_vtype_d;
   logic [VLW-1:0]   ds_vl_q, ds_vl_d;
   logic [7:0]       vsh_s;
   logic [7:0]       sh_new_s;
`ifdef RVV_CFG_VSETSH_EN
   logic [7:0]       vsh_q, vsh_d;
   logic [7:0]       ds_vsh_q, ds_vsh_d;
`endif

   // Decode
   logic is_vec_s, is_cfg_s, dec_vsetvli_s, dec_vsetivli_s, dec_vsetvl_s, dec_vsetsh_s;
   logic cfg_known_s, rs1_zero_s, rd_zero_s;
   logic [7:0]      zimm_s;
   logic            rsvd_nz_s, vtype_bad_s;
   logic [XLEN-1:0] avl_s;
   logic [4:0]      log2_sew_s;
   logic [5:0]      lg_vlmax_s;
   logic [VLW-1:0]  vlmax_s, vl_new_s;
   logic            unused_rs2_s;

   assign is_vec_s       = (instr_i[6:0] == OPC_V);
   assign is_cfg_s       = is_vec_s && (instr_i[14:12] == OPCFG);
   assign dec_vsetvli_s  = ~instr_i[31];
   assign dec_vsetivli_s = (instr_i[31:30] == 2'b11);
   assign dec_vsetvl_s   = (instr_i[31:25] == 7'b1000000);
`ifdef RVV_CFG_VSETSH_EN
   assign dec_vsetsh_s   = (instr_i[31:28] == 4'b1010);
   assign vsh_s          = vsh_q;
   assign ds_vsh_o       = ds_vsh_q;
`else
   assign dec_vsetsh_s   = 1'b0;
   assign vsh_s          = 8'h00;
   assign ds_vsh_o       = 8'h00;
`endif
   assign cfg_known_s    = dec_vsetvli_s | dec_vsetivli_s | dec_vsetvl_s | dec_vsetsh_s;
   assign rs1_zero_s     = (instr_i[19:15] == 5'd0);
   assign rd_zero_s      = (instr_i[11:7] == 5'd0);
   assign sh_new_s       = rs1_zero_s ? instr_i[27:20] : rs1_i[7:0];
   assign unused_rs2_s   = ^rs2_i[XLEN-1:8];

   // Select requested vtype field, its reserved bits, and the AVL source.
   always_comb begin
      zimm_s    = rs2_i[7:0];
      rsvd_nz_s = 1'b0;
      if (dec_vsetvli_s) begin
         zimm_s    = instr_i[27:20];
         rsvd_nz_s = |instr_i[30:28];
      end else if (dec_vsetivli_s) begin
         zimm_s    = instr_i[27:20];
         rsvd_nz_s = |instr_i[29:28];
      end else begin
         zimm_s    = rs2_i[7:0];
         rsvd_nz_s = 1'b0;
      end
      if (dec_vsetivli_s) begin
         avl_s = {{(XLEN-5){1'b0}}, instr_i[19:15]};
      end else if (!rs1_zero_s) begin
         avl_s = rs1_i;
      end else if (!rd_zero_s) begin
         avl_s = {XLEN{1'b1}};
      end else begin
         avl_s = {{(XLEN-VLW){1'b0}}, vl_q};
      end
   end

   // VLMAX by shifting: log2(VLEN) - log2(SEW) + signed LMUL; vl = min(AVL, VLMAX).
   assign vtype_bad_s = vtype_illegal(zimm_s, rsvd_nz_s);
   assign log2_sew_s  = 5'd3 + {2'b00, zimm_s[5:3]};
   assign lg_vlmax_s  = {1'b0, LOG2_VLEN} - {1'b0, log2_sew_s} + {{3{zimm_s[2]}}, zimm_s[2:0]};
   assign vlmax_s     = {{(VLW-1){1'b0}}, 1'b1} << lg_vlmax_s;
   assign vl_new_s    = (avl_s < {{(XLEN-VLW){1'b0}}, vlmax_s}) ? avl_s[VLW-1:0] : vlmax_s;

   // Next-state and datapath: accept in IDLE, answer in RESP, hold forward in ISSUE.
   always_comb begin
      state_d       = state_q;
      vtype_d       = vtype_q;
      vl_d          = vl_q;
      resp_valid_d  = 1'b0;
      resp_result_d = resp_result_q;
      resp_error_d  = resp_error_q;
      ds_valid_d    = ds_valid_q;
      ds_instr_d    = ds_instr_q;
      ds_vtype_d    = ds_vtype_q;
      ds_vl_d       = ds_vl_q;
`ifdef RVV_CFG_VSETSH_EN
      vsh_d         = vsh_q;
      ds_vsh_d      = ds_vsh_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (!instr_valid_i) begin
               state_d = ST_IDLE;
            end else if (!is_vec_s || (is_cfg_s && !cfg_known_s)) begin
               state_d       = ST_RESP;
               resp_valid_d  = 1'b1;
               resp_error_d  = 1'b1;
               resp_result_d = {XLEN{1'b0}};
            end else if (is_cfg_s) begin
               state_d      = ST_RESP;
               resp_valid_d = 1'b1;
               resp_error_d = 1'b0;
               if (dec_vsetsh_s) begin
                  resp_result_d = {{(XLEN-8){1'b0}}, vsh_s};
`ifdef RVV_CFG_VSETSH_EN
                  vsh_d         = sh_new_s;
`endif
               end else if (vtype_bad_s) begin
                  vtype_d       = VTYPE_VILL;
                  vl_d          = {VLW{1'b0}};
                  resp_result_d = {XLEN{1'b0}};
               end else begin
                  vtype_d       = {1'b0, zimm_s[7], zimm_s[6], zimm_s[4:3], zimm_s[2:0]};
                  vl_d          = vl_new_s;
                  resp_result_d = {{(XLEN-VLW){1'b0}}, vl_new_s};
               end
            end else begin
               state_d    = ST_ISSUE;
               ds_valid_d = 1'b1;
               ds_instr_d = instr_i;
               ds_vtype_d = vtype_q;
               ds_vl_d    = vl_q;
`ifdef RVV_CFG_VSETSH_EN
               ds_vsh_d   = vsh_q;
`endif
            end
         end
         ST_RESP: begin
            state_d = ST_IDLE;
         end
         ST_ISSUE: begin
            if (ds_ready_i) begin
               state_d    = ST_IDLE;
               ds_valid_d = 1'b0;
            end else begin
               state_d    = ST_ISSUE;
            end
         end
         default: begin
            state_d    = ST_IDLE;
            ds_valid_d = 1'b0;
         end
      endcase
   end

   // State and CSR registers with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q       <= ST_IDLE;
         vtype_q       <= VTYPE_VILL;
         vl_q          <= {VLW{1'b0}};
         resp_valid_q  <= 1'b0;
         resp_result_q <= {XLEN{1'b0}};
         resp_error_q  <= 1'b0;
         ds_valid_q    <= 1'b0;
         ds_instr_q    <= 32'h0000_0000;
         ds_vtype_q    <= 8'h00;
         ds_vl_q       <= {VLW{1'b0}};
`ifdef RVV_CFG_VSETSH_EN
         vsh_q         <= 8'h00;
         ds_vsh_q      <= 8'h00;
`endif
      end else begin
         state_q       <= state_d;
         vtype_q       <= vtype_d;
         vl_q          <= vl_d;
         resp_valid_q  <= resp_valid_d;
         resp_result_q <= resp_result_d;
         resp_error_q  <= resp_error_d;
         ds_valid_q    <= ds_valid_d;
         ds_instr_q    <= ds_instr_d;
         ds_vtype_q    <= ds_vtype_d;
         ds_vl_q       <= ds_vl_d;
`ifdef RVV_CFG_VSETSH_EN
         vsh_q         <= vsh_d;
         ds_vsh_q      <= ds_vsh_d;
`endif
      end
   end

   assign instr_ready_o = (state_q == ST_IDLE);
   assign resp_valid_o  = resp_valid_q;
   assign resp_result_o = resp_result_q;
   assign resp_error_o  = resp_error_q;
   assign ds_valid_o    = ds_valid_q;
   assign ds_instr_o    = ds_instr_q;
   assign ds_vtype_o    = ds_vtype_q;
   assign ds_vl_o       = ds_vl_q;
   assign vtype_o       = vtype_q;
   assign vl_o          = vl_q;
   assign vsh_o         = vsh_s;

endmodule

// File: tb/tb_rvv_cfg_decoder.sv
// Scoreboard bench for rvv_cfg_decoder (VLEN=4096, ELEN=64, XLEN=64).
module tb_rvv_cfg_decoder;

   localparam logic [6:0] OPC = 7'b1010111;
`ifdef RVV_CFG_VSETSH_EN
   localparam bit SH_EN = 1'b1;
`else
   localparam bit SH_EN = 1'b0;
`endif

   logic        clk_i = 1'b0;
   logic        rst_i, instr_valid_i, ds_ready_i;
   logic        instr_ready_o, resp_valid_o, resp_error_o, ds_valid_o;
   logic [31:0] instr_i, ds_instr_o;
   logic [63:0] rs1_i, rs2_i, resp_result_o;
   logic [7:0]  ds_vtype_o, ds_vsh_o, vtype_o, vsh_o;
   logic [12:0] ds_vl_o, vl_o;

   always #5 clk_i = ~clk_i;

   rvv_cfg_decoder dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .instr_valid_i(instr_valid_i), .instr_ready_o(instr_ready_o), .instr_i(instr_i),
      .rs1_i(rs1_i), .rs2_i(rs2_i),
      .resp_valid_o(resp_valid_o), .resp_result_o(resp_result_o), .resp_error_o(resp_error_o),
      .ds_valid_o(ds_valid_o), .ds_ready_i(ds_ready_i), .ds_instr_o(ds_instr_o),
      .ds_vtype_o(ds_vtype_o), .ds_vl_o(ds_vl_o), .ds_vsh_o(ds_vsh_o),
      .vtype_o(vtype_o), .vl_o(vl_o), .vsh_o(vsh_o)
   );

   typedef struct {
      bit          is_ds;
      logic [63:0] result;
      logic        error;
      logic [31:0] instr;
      logic [7:0]  vtype;
      logic [12:0] vl;
      logic [7:0]  vsh;
   } exp_t;

   exp_t sb[$];
   int checks = 0;
   int failures = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, req);
      end
   endtask

   function automatic logic [31:0] vsetvli(input logic [4:0] rd, input logic [4:0] rs1, input logic [10:0] z);
      return {1'b0, z, rs1, 3'b111, rd, OPC};
   endfunction
   function automatic logic [31:0] vsetivli(input logic [4:0] rd, input logic [4:0] u, input logic [9:0] z);
      return {2'b11, z, u, 3'b111, rd, OPC};
   endfunction
   function automatic logic [31:0] vsetvl(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
      return {7'b1000000, rs2, rs1, 3'b111, rd, OPC};
   endfunction
   function automatic logic [31:0] vsetsh(input logic [4:0] rd, input logic [4:0] rs1, input logic [7:0] u);
      return {4'b1010, u, rs1, 3'b111, rd, OPC};
   endfunction

   // Monitor: pop and compare on every response and every downstream transfer.
   always @(negedge clk_i) begin
      exp_t e;
      if (!rst_i && resp_valid_o) begin
         if (sb.size() == 0) begin
            chk("resp_unexpected", 64'd1, 64'd0);
         end else begin
            e = sb.pop_front();
            chk("resp_kind", 64'(e.is_ds), 64'd0);
            chk("resp_result", resp_result_o, e.result);
            chk("resp_error", 64'(resp_error_o), 64'(e.error));
         end
      end
      if (!rst_i && ds_valid_o && ds_ready_i) begin
         if (sb.size() == 0) begin
            chk("ds_unexpected", 64'd1, 64'd0);
         end else begin
            e = sb.pop_front();
            chk("ds_kind", 64'(e.is_ds), 64'd1);
            chk("ds_instr", 64'(ds_instr_o), 64'(e.instr));
            chk("ds_vtype", 64'(ds_vtype_o), 64'(e.vtype));
            chk("ds_vl", 64'(ds_vl_o), 64'(e.vl));
            chk("ds_vsh", 64'(ds_vsh_o), 64'(e.vsh));
         end
      end
   end

   task automatic issue(input logic [31:0] ins, input logic [63:0] a, input logic [63:0] b);
      int n = 0;
      @(negedge clk_i);
      while (!instr_ready_o && n < 20) begin
         @(negedge clk_i);
         n++;
      end
      if (!instr_ready_o) chk("ready_timeout", 64'd0, 64'd1);
      instr_i = ins; rs1_i = a; rs2_i = b; instr_valid_i = 1'b1;
      @(posedge clk_i); #1;
      instr_valid_i = 1'b0;
   endtask

   task automatic cfg(input string nm, input logic [31:0] ins, input logic [63:0] a, input logic [63:0] b,
                      input logic [63:0] res, input logic err, input logic [7:0] vt,
                      input logic [12:0] vl, input logic [7:0] vs);
      exp_t e;
      e.is_ds = 1'b0; e.result = res; e.error = err;
      e.instr = 32'h0; e.vtype = 8'h0; e.vl = 13'h0; e.vsh = 8'h0;
      sb.push_back(e);
      issue(ins, a, b);
      chk({nm, "_valid"}, 64'(resp_valid_o), 64'd1);
      chk({nm, "_busy"}, 64'(instr_ready_o), 64'd0);
      @(posedge clk_i); #1;
      chk({nm, "_valid_drop"}, 64'(resp_valid_o), 64'd0);
      chk({nm, "_vtype"}, 64'(vtype_o), 64'(vt));
      chk({nm, "_vl"}, 64'(vl_o), 64'(vl));
      chk({nm, "_vsh"}, 64'(vsh_o), 64'(vs));
   endtask

   task automatic push_ds(input logic [31:0] ins, input logic [7:0] vt, input logic [12:0] vl, input logic [7:0] vs);
      exp_t e;
      e.is_ds = 1'b1; e.result = 64'h0; e.error = 1'b0;
      e.instr = ins; e.vtype = vt; e.vl = vl; e.vsh = vs;
      sb.push_back(e);
   endtask

   logic [31:0] vadd;
   logic [7:0]  sh_a, sh_b;

   initial begin
      vadd = {6'b000000, 1'b1, 5'd2, 5'd3, 3'b000, 5'd1, OPC};
      sh_a = SH_EN ? 8'h0C : 8'h00;
      sh_b = SH_EN ? 8'h03 : 8'h00;
      rst_i = 1'b1; instr_valid_i = 1'b0; instr_i = 32'h0; rs1_i = 64'h0; rs2_i = 64'h0; ds_ready_i = 1'b0;
      repeat (3) @(posedge clk_i);
      #1 rst_i = 1'b0;
      chk("rst_vtype", 64'(vtype_o), 64'h80);
      chk("rst_vl", 64'(vl_o), 64'd0);
      chk("rst_vsh", 64'(vsh_o), 64'd0);
      chk("rst_ready", 64'(instr_ready_o), 64'd1);
      chk("rst_resp_valid", 64'(resp_valid_o), 64'd0);
      chk("rst_resp_result", resp_result_o, 64'd0);
      chk("rst_ds_valid", 64'(ds_valid_o), 64'd0);
      chk("rst_ds_instr", 64'(ds_instr_o), 64'd0);

      cfg("vsetvli_m2", vsetvli(5'd1, 5'd2, 11'h011), 64'd1000, 64'd0, 64'd256, 1'b0, 8'h11, 13'd256, 8'h00);
      cfg("vsetivli_mf8", vsetivli(5'd1, 5'd5, 10'h005), 64'd0, 64'd0, 64'd5, 1'b0, 8'h05, 13'd5, 8'h00);
      cfg("vsetvl_rsvd", vsetvl(5'd1, 5'd2, 5'd3), 64'd100, 64'h04, 64'd0, 1'b0, 8'h80, 13'd0, 8'h00);
      cfg("vsetvli_vlmax", vsetvli(5'd1, 5'd0, 11'h01B), 64'd0, 64'd0, 64'd512, 1'b0, 8'h1B, 13'd512, 8'h00);
      cfg("vsetvli_keep", vsetvli(5'd0, 5'd0, 11'h018), 64'd0, 64'd0, 64'd64, 1'b0, 8'h18, 13'd64, 8'h00);
      cfg("vsetvli_tama", vsetvli(5'd1, 5'd2, 11'h0D0), 64'd2000, 64'd0, 64'd128, 1'b0, 8'h70, 13'd128, 8'h00);
      cfg("vsetvli_wide_avl", vsetvli(5'd1, 5'd2, 11'h017), 64'h1_0000_0000, 64'd0, 64'd64, 1'b0, 8'h17, 13'd64, 8'h00);
      cfg("vsetvli_zimm_rsvd", vsetvli(5'd1, 5'd2, 11'h111), 64'd10, 64'd0, 64'd0, 1'b0, 8'h80, 13'd0, 8'h00);
      cfg("vsetivli_m1", vsetivli(5'd1, 5'd7, 10'h000), 64'd0, 64'd0, 64'd7, 1'b0, 8'h00, 13'd7, 8'h00);
      cfg("vsetvl_frac_ovf", vsetvl(5'd1, 5'd2, 5'd3), 64'd10, 64'h1F, 64'd0, 1'b0, 8'h80, 13'd0, 8'h00);
      cfg("vsetivli_31", vsetivli(5'd1, 5'd31, 10'h018), 64'd0, 64'd0, 64'd31, 1'b0, 8'h18, 13'd31, 8'h00);
      cfg("bad_opcode", 32'h0000_0013, 64'd5, 64'd5, 64'd0, 1'b1, 8'h18, 13'd31, 8'h00);
      cfg("bad_opcfg", {7'b1000001, 5'd3, 5'd2, 3'b111, 5'd1, OPC}, 64'd5, 64'd5, 64'd0, 1'b1, 8'h18, 13'd31, 8'h00);
      cfg("vsetsh_imm", vsetsh(5'd1, 5'd0, 8'h0C), 64'd0, 64'd0, 64'd0, !SH_EN, 8'h18, 13'd31, sh_a);
      cfg("vsetsh_rs1", vsetsh(5'd1, 5'd5, 8'h55), 64'd3, 64'd0, SH_EN ? 64'd12 : 64'd0, !SH_EN, 8'h18, 13'd31, sh_b);

      // Forward with four stalled cycles.
      push_ds(vadd, 8'h18, 13'd31, sh_b);
      issue(vadd, 64'd0, 64'd0);
      for (int i = 0; i < 4; i++) begin
         chk("stall_valid", 64'(ds_valid_o), 64'd1);
         chk("stall_instr", 64'(ds_instr_o), 64'(vadd));
         chk("stall_vl", 64'(ds_vl_o), 64'd31);
         chk("stall_ready", 64'(instr_ready_o), 64'd0);
         @(posedge clk_i); #1;
      end
      ds_ready_i = 1'b1;
      chk("xfer_valid", 64'(ds_valid_o), 64'd1);
      @(posedge clk_i); #1;
      ds_ready_i = 1'b0;
      chk("xfer_drop", 64'(ds_valid_o), 64'd0);
      chk("xfer_ready", 64'(instr_ready_o), 64'd1);

      // Reset while a forward is pending: no expectation pushed.
      issue(vadd, 64'd0, 64'd0);
      @(posedge clk_i); #1;
      rst_i = 1'b1;
      @(posedge clk_i); #1;
      rst_i = 1'b0;
      chk("midrst_ds_valid", 64'(ds_valid_o), 64'd0);
      chk("midrst_vl", 64'(vl_o), 64'd0);
      chk("midrst_vtype", 64'(vtype_o), 64'h80);
      chk("midrst_vsh", 64'(vsh_o), 64'd0);
      chk("midrst_ready", 64'(instr_ready_o), 64'd1);
      chk("midrst_resp", 64'(resp_valid_o), 64'd0);

      // AVL = current vl (zero after reset), then a forward with ready held high.
      cfg("vsetvli_avl0", vsetvli(5'd0, 5'd0, 11'h018), 64'd0, 64'd0, 64'd0, 1'b0, 8'h18, 13'd0, 8'h00);
      ds_ready_i = 1'b1;
      push_ds(vadd, 8'h18, 13'd0, 8'h00);
      issue(vadd, 64'd0, 64'd0);
      chk("fast_valid", 64'(ds_valid_o), 64'd1);
      @(posedge clk_i); #1;
      chk("fast_drop", 64'(ds_valid_o), 64'd0);
      ds_ready_i = 1'b0;
      repeat (2) @(posedge clk_i);
      #1 chk("sb_empty", 64'(sb.size()), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Hard time limit so the run always terminates.
   initial begin
      #200000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

endmodule
